// File: rtl/esp_uart_rxfifo_if.sv
// Bus between the UART receive FIFO and its neighbours: receiver strobes and
// error levels in, consumer pop/clear in, show-ahead data and status out.
interface esp_uart_rxfifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_framing_error;
    logic                rx_break;
    logic                rd_en;
    logic                status_clr;
    logic [7:0]          rd_data;
    logic                rd_empty;
    logic                rd_full;
    logic [DEPTH_LOG2:0] rd_level;
    logic                overflow;
    logic                framing_err;
    logic                break_det;
    logic                irq;

    modport master (
        output rx_data, rx_valid, rx_framing_error, rx_break, rd_en, status_clr,
        input  rd_data, rd_empty, rd_full, rd_level, overflow, framing_err,
               break_det, irq
    );

    modport slave (
        input  rx_data, rx_valid, rx_framing_error, rx_break, rd_en, status_clr,
        output rd_data, rd_empty, rd_full, rd_level, overflow, framing_err,
               break_det, irq
    );
endinterface

// File: rtl/esp_uart_rxfifo.sv
// UART receive FIFO with show-ahead read, sticky overflow/framing/break flags
// and a level-or-error interrupt request.
module esp_uart_rxfifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int IRQ_LEVEL  = 8
) (
    input  logic             clk,
    input  logic             rst,
    esp_uart_rxfifo_if.slave bus
);
    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned IRQ_THR = IRQ_LEVEL;

    logic [7:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                r_overflow;
    logic                r_framing_err;
    logic                r_break_det;
    logic                r_fe_q;
    logic                r_brk_q;

    logic                w_empty;
    logic                w_full;
    logic [DEPTH_LOG2:0] w_level;
    logic                w_push;
    logic                w_pop;
    logic                w_ovf_event;
    logic                w_fe_rise;
    logic                w_brk_rise;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                     (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
    assign w_level = r_wr_ptr - r_rd_ptr;

    assign w_push      = bus.rx_valid && !w_full;
    assign w_pop       = bus.rd_en && !w_empty;
    assign w_ovf_event = bus.rx_valid && w_full;
    assign w_fe_rise   = bus.rx_framing_error && !r_fe_q;
    assign w_brk_rise  = bus.rx_break && !r_brk_q;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky flags: a set event in the same cycle as status_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow    <= 1'b0;
            r_framing_err <= 1'b0;
            r_break_det   <= 1'b0;
            r_fe_q        <= 1'b0;
            r_brk_q       <= 1'b0;
        end else begin
            r_fe_q  <= bus.rx_framing_error;
            r_brk_q <= bus.rx_break;

            if (w_ovf_event)         r_overflow <= 1'b1;
            else if (bus.status_clr) r_overflow <= 1'b0;

            if (w_fe_rise)           r_framing_err <= 1'b1;
            else if (bus.status_clr) r_framing_err <= 1'b0;

            if (w_brk_rise)          r_break_det <= 1'b1;
            else if (bus.status_clr) r_break_det <= 1'b0;
        end
    end

    assign bus.rd_data     = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign bus.rd_empty    = w_empty;
    assign bus.rd_full     = w_full;
    assign bus.rd_level    = w_level;
    assign bus.overflow    = r_overflow;
    assign bus.framing_err = r_framing_err;
    assign bus.break_det   = r_break_det;
    assign bus.irq         = (32'(w_level) >= IRQ_THR) | r_overflow |
                             r_framing_err | r_break_det;
endmodule

// File: doc/esp_uart_rxfifo.md
ESP_UART_RXFIFO -- requirements
Module: esp_uart_rxfifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2^DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter IRQ_LEVEL, default 8, fill level at/above which irq asserts.
REQ-003 SHALL have: clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have: rx_data  input  8  received byte from UART receiver.
REQ-006 SHALL have: rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-007 SHALL have: rx_framing_error  input  1  level from receiver, high while a framing error is pending.
REQ-008 SHALL have: rx_break  input  1  level from receiver, high while a break is pending.
REQ-009 SHALL have: rd_en  input  1  pop request from consumer.
REQ-010 SHALL have: status_clr  input  1  clears all sticky status flags.
REQ-011 SHALL have: rd_data  output  8  head-of-FIFO byte (show-ahead).
REQ-012 SHALL have: rd_empty  output  1  FIFO empty.
REQ-013 SHALL have: rd_full  output  1  FIFO full.
REQ-014 SHALL have: rd_level  output  DEPTH_LOG2+1  number of stored bytes.
REQ-015 SHALL have: overflow  output  1  sticky, byte dropped because FIFO full.
REQ-016 SHALL have: framing_err  output  1  sticky, framing error seen.
REQ-017 SHALL have: break_det  output  1  sticky, break seen.
REQ-018 SHALL have: irq  output  1  interrupt request.

Function
REQ-019 SHALL store bytes in a 2^DEPTH_LOG2 x 8 array addressed by write/read pointers of DEPTH_LOG2+1 bits (MSB = wrap bit), pointers wrap modulo 2^(DEPTH_LOG2+1).
REQ-020 SHALL derive empty = (wr_ptr == rd_ptr); full = low bits equal and wrap bits differ; rd_level = wr_ptr - rd_ptr, modulo width.
REQ-021 SHALL push rx_data when rx_valid=1 and rd_full=0 (registered full value of that cycle).
REQ-022 SHALL drop the byte and set overflow when rx_valid=1 and rd_full=1, even if a pop occurs in the same cycle.
REQ-023 SHALL pop (advance rd_ptr) when rd_en=1 and rd_empty=0; rd_en while empty SHALL be ignored, no pointer change.
REQ-024 SHALL, on simultaneous push and pop (not full, not empty), leave rd_level unchanged.
REQ-025 SHALL, on simultaneous push with rd_en while empty, perform only the push.
REQ-026 SHALL present rd_data = array[rd_ptr low bits] combinationally; value undefined-but-stable when empty.
REQ-027 SHALL have latency: byte pushed at edge N visible on rd_data with rd_empty=0 after edge N (i.e. in cycle N+1).
REQ-028 SHALL register rx_framing_error and rx_break one cycle and set framing_err / break_det on their rising edge (0->1) only.
REQ-029 SHALL clear overflow, framing_err, break_det on status_clr=1; a set event in the same cycle SHALL win over clear.
REQ-030 SHALL drive irq = (rd_level >= IRQ_LEVEL) | overflow | framing_err | break_det, from registered state only.
REQ-031 SHALL not alter FIFO contents or pointers on error events; error bytes are never pushed.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set wr_ptr=rd_ptr=0, rd_empty=1, rd_full=0, rd_level=0, overflow=framing_err=break_det=0, irq=0, edge-detect registers=0.
REQ-033 SHALL give rst priority over push, pop and status_clr in the same cycle; array contents need not be cleared.
REQ-034 SHALL, when rst asserts mid-stream, discard all stored bytes; first post-reset push lands at address 0.

Verification
REQ-035 SHALL cover: push 0x41,0x42,0x43 one per 8 cycles, then rd_en x3 -> rd_data 0x41,0x42,0x43 in order, rd_level 3->0, rd_empty=1.
REQ-036 SHALL cover: DEPTH_LOG2=4, push 17 bytes 0x00..0x10 -> rd_full=1 after 16th, 0x10 dropped, overflow=1, irq=1; pop all -> 0x00..0x0F; status_clr -> overflow=0.
REQ-037 SHALL cover: full FIFO, rx_valid and rd_en same cycle -> byte dropped, overflow=1, rd_level=15.
REQ-038 SHALL cover: rx_break held high 20 cycles -> break_det=1 one cycle after rise, set once; status_clr while rx_break still high -> break_det=0, no re-set until next rising edge.
REQ-039 SHALL cover: push 8 bytes (IRQ_LEVEL=8) -> irq=1 after 8th push; one pop -> irq=0; rst mid-fill -> rd_level=0, irq=0, next byte 0x55 read back first.
REQ-040 SHALL cover: pointer wrap, 40 push/pop pairs through depth 16 -> data order intact, rd_level never exceeds 1.
